// File: rtl/md_unit_pkg.sv
// Shared types and constants for the multiply/divide unit: operation encodings,
// default latencies and datapath widths.
package md_unit_pkg;

   localparam int DATA_W         = 32;
   localparam int RES_W          = 64;
   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Two's-complement magnitude; INT_MIN maps to 0x80000000, which is correct as unsigned.
   function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
      return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the core and the multiply/divide unit.
interface md_unit_if;
   import md_unit_pkg::*;

   logic              start;
   md_op_e            md_op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              we_hi;
   logic              we_lo;
   logic              busy;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, md_op, src_a, src_b, we_hi, we_lo,
      input  busy, hi, lo
   );

   modport slave (
      input  start, md_op, src_a, src_b, we_hi, we_lo,
      output busy, hi, lo
   );

endinterface

// File: rtl/md_unit_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the full {hi,lo} result.
module md_arith
   import md_unit_pkg::*;
(
   input  md_op_e            md_op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [RES_W-1:0]  result,
   output logic              div_by_zero
);

   logic signed [RES_W-1:0] a_s, b_s, prod_s;
   logic [RES_W-1:0]        a_u, b_u, prod_u;
   logic [DATA_W-1:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
   logic                    signed_div, q_neg, r_neg;

   always_comb begin
      a_s    = RES_W'($signed(a));
      b_s    = RES_W'($signed(b));
      a_u    = {{(RES_W-DATA_W){1'b0}}, a};
      b_u    = {{(RES_W-DATA_W){1'b0}}, b};
      prod_s = a_s * b_s;
      prod_u = a_u * b_u;

      // Signed divide is done on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
      signed_div  = (md_op == MD_DIV);
      div_by_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (b == '0);
      a_mag       = signed_div ? abs_val($signed(a)) : a;
      b_mag       = signed_div ? abs_val($signed(b)) : b;
      b_safe      = (b == '0) ? DATA_W'(1) : b_mag;
      q_mag       = a_mag / b_safe;
      r_mag       = a_mag % b_safe;
      q_neg       = signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
      r_neg       = signed_div & a[DATA_W-1];
      quo         = q_neg ? DATA_W'(-q_mag) : q_mag;
      rem         = r_neg ? DATA_W'(-r_mag) : r_mag;

      result = '0;
      case (md_op)
         MD_MULT:  result = RES_W'(prod_s);
         MD_MULTU: result = prod_u;
         default:  result = {rem, quo};
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result is computed at
// start, held pending, and committed to HI/LO when the busy countdown expires.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic     clk,
   input  logic     reset_n,
   md_unit_if.slave bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [RES_W-1:0]  pend_res_p1;
   logic              pend_commit_p1;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic [RES_W-1:0]  arith_res;
   logic              arith_dbz;
   logic              is_div;
   logic              last_cycle;

   md_arith u_arith (
      .md_op       (bus.md_op),
      .a           (bus.src_a),
      .b           (bus.src_b),
      .result      (arith_res),
      .div_by_zero (arith_dbz)
   );

   assign is_div     = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
   assign last_cycle = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (last_cycle) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == ST_RUN);
   end

   // Countdown, pending result and architectural HI/LO; starts win over MTHI/MTLO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= '0;
         pend_res_p1    <= '0;
         pend_commit_p1 <= 1'b0;
         hi_q           <= '0;
         lo_q           <= '0;
      end else if (state_q == ST_IDLE) begin
         if (bus.start) begin
            pend_res_p1    <= arith_res;
            pend_commit_p1 <= ~arith_dbz;
            cnt_q          <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else begin
            if (bus.we_hi) hi_q <= bus.src_a;
            if (bus.we_lo) lo_q <= bus.src_a;
         end
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (last_cycle && pend_commit_p1) begin
            hi_q <= pend_res_p1[RES_W-1:DATA_W];
            lo_q <= pend_res_p1[DATA_W-1:0];
         end
      end
   end

   assign bus.hi = hi_q;
   assign bus.lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic reference.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   md_unit_if mif();

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (mif)
   );

   int   total = 0;
   int   bad   = 0;
   bit   allow_overlap = 1'b0;
   logic [31:0] m_hi, m_lo;

   typedef struct {
      md_op_e      op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       nm;
   } vec_t;

   vec_t vt[6];

   always @(posedge clk) begin
      if (reset_n === 1'b1 && !allow_overlap)
         assert (!(mif.start === 1'b1 && mif.busy === 1'b1)) else $error("start issued while busy");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void ref_res(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output bit dz);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      dz = 1'b0;
      h  = '0;
      l  = '0;
      p  = '0;
      case (op)
         MD_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         MD_MULTU: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
         MD_DIV: begin
            if (b == 0) dz = 1'b1;
            else begin l = 32'(sa / sb); h = 32'(sa % sb); end
         end
         default: begin
            if (b == 0) dz = 1'b1;
            else begin l = 32'(ua / ub); h = 32'(ua % ub); end
         end
      endcase
   endfunction

   // Issue one operation from idle and count busy cycles until busy falls.
   task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic wl, output int ncyc);
      mif.start = 1'b1;
      mif.md_op = op;
      mif.src_a = a;
      mif.src_b = b;
      mif.we_lo = wl;
      tick();
      mif.start = 1'b0;
      mif.we_lo = 1'b0;
      chk("nobypass_hi", mif.hi, m_hi);
      chk("nobypass_lo", mif.lo, m_lo);
      ncyc = 0;
      while (mif.busy === 1'b1 && ncyc < 64) begin
         ncyc++;
         tick();
      end
   endtask

   task automatic mtx(input logic wh, input logic wl, input logic [31:0] v);
      mif.we_hi = wh;
      mif.we_lo = wl;
      mif.src_a = v;
      tick();
      mif.we_hi = 1'b0;
      mif.we_lo = 1'b0;
      if (wh) m_hi = v;
      if (wl) m_lo = v;
   endtask

   initial begin
      int          n;
      logic [31:0] eh, el, a, b;
      bit          dz;
      md_op_e      op;

      vt[0] = '{MD_MULT,  32'd3,        32'd4,        32'h0000_0000, 32'h0000_000C, "mult_3x4"};
      vt[1] = '{MD_MULT,  32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_m1x2"};
      vt[2] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001, 32'hFFFF_FFFE, "multu_ffx2"};
      vt[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
      vt[4] = '{MD_DIVU,  32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003, "divu_7_2"};
      vt[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1"};

      mif.start = 1'b0;
      mif.md_op = MD_MULT;
      mif.src_a = '0;
      mif.src_b = '0;
      mif.we_hi = 1'b0;
      mif.we_lo = 1'b0;
      reset_n   = 1'b0;
      #12;
      chk("rst_hi", mif.hi, 32'h0);
      chk("rst_lo", mif.lo, 32'h0);
      chk("rst_busy", 32'(mif.busy), 32'h0);
      tick();
      reset_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, 1'b0, n);
         chk({vt[i].nm, "_cycles"}, 32'(n), (vt[i].op == MD_DIV || vt[i].op == MD_DIVU) ? DC : MC);
         chk({vt[i].nm, "_hi"}, mif.hi, vt[i].hi);
         chk({vt[i].nm, "_lo"}, mif.lo, vt[i].lo);
         m_hi = vt[i].hi;
         m_lo = vt[i].lo;
      end

      // MTHI/MTLO preload then divide by zero leaves HI/LO untouched
      mtx(1'b1, 1'b0, 32'hAAAA_0000);
      chk("mthi", mif.hi, 32'hAAAA_0000);
      mtx(1'b0, 1'b1, 32'h0000_5555);
      chk("mtlo", mif.lo, 32'h0000_5555);
      run_op(MD_DIVU, 32'h1234, 32'h0, 1'b0, n);
      chk("dbz_cycles", 32'(n), DC);
      chk("dbz_hi", mif.hi, 32'hAAAA_0000);
      chk("dbz_lo", mif.lo, 32'h0000_5555);

      mtx(1'b1, 1'b1, 32'hC0FF_EE00);
      chk("mtboth_hi", mif.hi, 32'hC0FF_EE00);
      chk("mtboth_lo", mif.lo, 32'hC0FF_EE00);

      // start and MTHI during busy are ignored; original MULT commits on schedule
      allow_overlap = 1'b1;
      mif.start = 1'b1;
      mif.md_op = MD_MULT;
      mif.src_a = 32'h100;
      mif.src_b = 32'h100;
      tick();
      mif.start = 1'b0;
      n = 0;
      for (int c = 0; c < 64 && mif.busy === 1'b1; c++) begin
         n++;
         if (n == 2) begin
            mif.start = 1'b1;
            mif.md_op = MD_DIV;
            mif.src_a = 32'd100;
            mif.src_b = 32'd7;
            mif.we_hi = 1'b1;
            mif.we_lo = 1'b1;
            mif.src_a = 32'hDEAD_0000;
         end else begin
            mif.start = 1'b0;
            mif.we_hi = 1'b0;
            mif.we_lo = 1'b0;
         end
         tick();
      end
      mif.start = 1'b0;
      mif.we_hi = 1'b0;
      mif.we_lo = 1'b0;
      allow_overlap = 1'b0;
      chk("ovl_cycles", 32'(n), MC);
      chk("ovl_hi", mif.hi, 32'h0);
      chk("ovl_lo", mif.lo, 32'h0001_0000);
      m_hi = 32'h0;
      m_lo = 32'h0001_0000;
      tick();
      chk("ovl_idle", 32'(mif.busy), 32'h0);

      // MTLO in the same cycle as start is dropped
      run_op(MD_MULTU, 32'd6, 32'd7, 1'b1, n);
      chk("startwe_cycles", 32'(n), MC);
      chk("startwe_hi", mif.hi, 32'h0);
      chk("startwe_lo", mif.lo, 32'd42);
      m_hi = 32'h0;
      m_lo = 32'd42;

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            a = $urandom;
            mtx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
            chk("rnd_mt_hi", mif.hi, m_hi);
            chk("rnd_mt_lo", mif.lo, m_lo);
         end else begin
            op = md_op_e'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
               0:       b = 32'h0;
               1:       b = 32'hFFFF_FFFF;
               2:       b = 32'($urandom_range(1, 15));
               default: b = 32'($urandom);
            endcase
            ref_res(op, a, b, eh, el, dz);
            run_op(op, a, b, 1'b0, n);
            chk("rnd_cycles", 32'(n), (op == MD_DIV || op == MD_DIVU) ? DC : MC);
            if (!dz) begin
               m_hi = eh;
               m_lo = el;
            end
            chk("rnd_hi", mif.hi, m_hi);
            chk("rnd_lo", mif.lo, m_lo);
         end
      end

      // Asynchronous reset in the middle of a divide aborts it
      mtx(1'b1, 1'b1, 32'h1357_9BDF);
      mif.start = 1'b1;
      mif.md_op = MD_DIV;
      mif.src_a = 32'd100;
      mif.src_b = 32'd7;
      tick();
      mif.start = 1'b0;
      repeat (3) tick();
      chk("midrst_busy_before", 32'(mif.busy), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(mif.busy), 32'h0);
      chk("midrst_hi", mif.hi, 32'h0);
      chk("midrst_lo", mif.lo, 32'h0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (15) tick();
      chk("postrst_busy", 32'(mif.busy), 32'h0);
      chk("postrst_hi", mif.hi, 32'h0);
      chk("postrst_lo", mif.lo, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
